// File: rtl/adder_subtractor_continuous.sv
// N-bit add/subtract sharing one carry chain, one registered result stage.
// Define ADDSUB_FLAGS_EN to build the registered V (overflow) and Z (zero) flags.
module adder_subtractor_continuous #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         mode,
  output logic         out_valid,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         V,
  output logic         Z
);

  logic [N-1:0] bx;
  logic [N:0]   sum;
  logic [N-1:0] s;
  logic         c;

  // subtract reuses the adder: invert B and inject mode as carry-in
  always_comb begin
    bx  = B ^ {N{mode}};
    sum = {1'b0, A} + {1'b0, bx} + {{N{1'b0}}, mode};
    s   = sum[N-1:0];
    c   = sum[N];
  end

  // result register: captures only on valid, holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      S    <= '0;
      Cout <= 1'b0;
    end else if (in_valid) begin
      S    <= s;
      Cout <= c;
    end
  end

  // valid tracks the previous cycle's capture
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end

`ifdef ADDSUB_FLAGS_EN
  logic v_d;
  logic z_d;

  // overflow: like-signed operands giving an opposite-signed result
  always_comb begin
    v_d = (A[N-1] == bx[N-1]) && (s[N-1] != A[N-1]);
    z_d = (s == '0);
  end

  // flags register alongside S with identical timing
  always_ff @(posedge clk) begin
    if (rst) begin
      V <= 1'b0;
      Z <= 1'b0;
    end else if (in_valid) begin
      V <= v_d;
      Z <= z_d;
    end
  end
`else
  assign V = 1'b0;
  assign Z = 1'b0;
`endif

endmodule

// File: tb/tb_adder_subtractor_continuous.sv
// Directed bench for adder_subtractor_continuous (N=8).
// Flag expectations follow ADDSUB_FLAGS_EN; V/Z expected 0 otherwise.
module tb_adder_subtractor_continuous;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic       mode;
  logic       out_valid;
  logic [7:0] S;
  logic       Cout;
  logic       V;
  logic       Z;

  int tests;
  int fails;

  adder_subtractor_continuous #(.N(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .mode     (mode),
    .out_valid(out_valid),
    .S        (S),
    .Cout     (Cout),
    .V        (V),
    .Z        (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic m);
    @(negedge clk);
    rst      = r;
    in_valid = iv;
    A        = a;
    B        = b;
    mode     = m;
    @(posedge clk);
    #1;
  endtask

  task automatic res(input string tag, input logic [7:0] es,
                     input logic ec, input logic ev, input logic ez);
    logic fv;
    logic fz;
`ifdef ADDSUB_FLAGS_EN
    fv = ev;
    fz = ez;
`else
    fv = 1'b0;
    fz = 1'b0;
`endif
    chk({tag, ".ov"}, 32'(out_valid), 32'd1);
    chk({tag, ".S"},  32'(S),         32'(es));
    chk({tag, ".C"},  32'(Cout),      32'(ec));
    chk({tag, ".V"},  32'(V),         32'(fv));
    chk({tag, ".Z"},  32'(Z),         32'(fz));
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    mode     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("rst.ov", 32'(out_valid), 32'd0);
    chk("rst.S",  32'(S),         32'd0);
    chk("rst.C",  32'(Cout),      32'd0);
    chk("rst.V",  32'(V),         32'd0);
    chk("rst.Z",  32'(Z),         32'd0);

    drive(1'b0, 1'b1, 8'd1, 8'd2, 1'b0);
    res("add1", 8'd3, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'd127, 8'd1, 1'b0);
    res("addov", 8'd128, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 8'd137, 8'd3, 1'b1);
    res("sub1", 8'd134, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'd4, 8'd10, 1'b1);
    res("subneg", 8'd250, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'd255, 8'd255, 1'b0);
    res("addwrap", 8'd254, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'd255, 8'd1, 1'b1);
    res("sub255", 8'd254, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'd170, 8'd170, 1'b1);
    res("subzero", 8'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'd77, 8'd0, 1'b1);
    res("subb0", 8'd77, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'd128, 8'd1, 1'b1);
    res("subov", 8'd127, 1'b1, 1'b1, 1'b0);

    drive(1'b0, 1'b0, 8'bx, 8'bx, 1'bx);
    chk("gap.ov", 32'(out_valid), 32'd0);
    chk("gap.S",  32'(S),         32'd127);
    chk("gap.C",  32'(Cout),      32'd1);
`ifdef ADDSUB_FLAGS_EN
    chk("gap.V",  32'(V),         32'd1);
`else
    chk("gap.V",  32'(V),         32'd0);
`endif

    drive(1'b0, 1'b1, 8'd10, 8'd20, 1'b0);
    res("b2b0", 8'd30, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'd200, 8'd100, 1'b0);
    res("b2b1", 8'd44, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'd50, 8'd60, 1'b1);
    res("b2b2", 8'd246, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 1'b1, 8'd9, 8'd9, 1'b0);
    chk("mrst.ov", 32'(out_valid), 32'd0);
    chk("mrst.S",  32'(S),         32'd0);
    chk("mrst.C",  32'(Cout),      32'd0);
    chk("mrst.V",  32'(V),         32'd0);
    chk("mrst.Z",  32'(Z),         32'd0);

    drive(1'b0, 1'b1, 8'd5, 8'd5, 1'b1);
    res("post", 8'd0, 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
